// File: rtl/acc_drain.sv
// Ping-pong accumulator tile buffer feeding the PPU. Upstream writes 16-row tiles
// into alternating banks while the read FSM drains each full bank as a start pulse plus 16 rows.
module acc_drain #(
  parameter int LANES  = 16,
  parameter int DATA_W = 24,
  parameter int ROWS   = 16,
  parameter int M      = 64,
  parameter int N      = 64,
  localparam int MAX_TILE = (M / ROWS) * (N / LANES),
  localparam int CNT_W    = (MAX_TILE > 1) ? $clog2(MAX_TILE) : 1,
  localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int ROW_BITS = LANES * DATA_W
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_wr_valid,
  output logic                o_wr_ready,
  input  logic [ROW_BITS-1:0] i_wr_data,
  input  logic [1:0]          i_mode,
  input  logic                i_relu_en,
  output logic                o_ppu_start,
  output logic [ROW_BITS-1:0] o_acc_data,
  output logic [1:0]          o_mode,
  output logic                o_relu_en,
  output logic [CNT_W-1:0]    o_tile_cnt,
  output logic                o_mat_done,
  output logic                o_busy
);

  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] TILE_LAST = CNT_W'(MAX_TILE - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [1:0]          full;
  logic                wr_bank;
  logic                rd_bank;
  logic [ROW_W-1:0]    wr_row;
  logic [ROW_W-1:0]    rd_row;
  logic [CNT_W-1:0]    tile_cnt;
  logic                mat_done_p1;
  logic [1:0]          mode_q;
  logic                relu_q;
  logic                wr_fire;
  logic                wr_last;
  logic                start;
  logic                rd_last;

  // Bank storage and tags carry no reset; the full flags decide what is valid.
  logic [ROW_BITS-1:0] bank_mem [2][ROWS];
  logic [1:0]          tag_mode [2];
  logic                tag_relu [2];

  assign wr_fire = i_wr_valid && !full[wr_bank];
  assign wr_last = wr_fire && (wr_row == ROW_LAST);
  assign start   = (state == IDLE) && full[rd_bank];
  assign rd_last = (state == SEND) && (rd_row == ROW_LAST);

  // ---- write side: row counter, bank select, full flags ----
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_row  <= '0;
      wr_bank <= 1'b0;
    end else if (wr_fire) begin
      if (wr_last) begin
        wr_row  <= '0;
        wr_bank <= ~wr_bank;
      end else begin
        wr_row <= wr_row + ROW_W'(1);
      end
    end
  end

  // Fill and drain never touch the same bank, so set and clear cannot collide.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      full <= '0;
    end else begin
      if (wr_last) full[wr_bank] <= 1'b1;
      if (rd_last) full[rd_bank] <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_fire) begin
      bank_mem[wr_bank][wr_row] <= i_wr_data;
      if (wr_row == '0) begin
        tag_mode[wr_bank] <= i_mode;
        tag_relu[wr_bank] <= i_relu_en;
      end
    end
  end

  // ---- read FSM: state register ----
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (full[rd_bank]) state_nxt = SEND;
      SEND:    if (rd_row == ROW_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- read side: row pointer, bank select, tile counter, tag hold ----
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_row      <= '0;
      rd_bank     <= 1'b0;
      tile_cnt    <= '0;
      mat_done_p1 <= 1'b0;
      mode_q      <= '0;
      relu_q      <= 1'b0;
    end else begin
      mat_done_p1 <= rd_last && (tile_cnt == TILE_LAST);
      if (start) begin
        rd_row <= '0;
        mode_q <= tag_mode[rd_bank];
        relu_q <= tag_relu[rd_bank];
      end else if (state == SEND) begin
        if (rd_last) begin
          rd_row   <= '0;
          rd_bank  <= ~rd_bank;
          tile_cnt <= (tile_cnt == TILE_LAST) ? '0 : tile_cnt + CNT_W'(1);
        end else begin
          rd_row <= rd_row + ROW_W'(1);
        end
      end
    end
  end

  // ---- outputs ----
  // The tag is shown straight from the bank during the start cycle, then held.
  always_comb begin
    o_ppu_start = start;
    o_acc_data  = (state == SEND) ? bank_mem[rd_bank][rd_row] : '0;
    o_mode      = start ? tag_mode[rd_bank] : mode_q;
    o_relu_en   = start ? tag_relu[rd_bank] : relu_q;
    o_tile_cnt  = tile_cnt;
    o_mat_done  = mat_done_p1;
    o_busy      = (|full) || (state == SEND);
    o_wr_ready  = !full[wr_bank];
  end

endmodule

// File: tb/tb_acc_drain.sv
// Scoreboard bench for acc_drain: accepted rows and tile tags are queued by the
// driver, and a negedge monitor checks the drained stream against a tile-count model.
module tb_acc_drain;
  localparam int LANES    = 16;
  localparam int DATA_W   = 24;
  localparam int ROWS     = 16;
  localparam int M        = 32;
  localparam int N        = 32;
  localparam int MAX_TILE = (M / ROWS) * (N / LANES);
  localparam int CNT_W    = (MAX_TILE > 1) ? $clog2(MAX_TILE) : 1;
  localparam int RW       = LANES * DATA_W;

  logic             i_clk;
  logic             i_rst;
  logic             i_wr_valid;
  logic             o_wr_ready;
  logic [RW-1:0]    i_wr_data;
  logic [1:0]       i_mode;
  logic             i_relu_en;
  logic             o_ppu_start;
  logic [RW-1:0]    o_acc_data;
  logic [1:0]       o_mode;
  logic             o_relu_en;
  logic [CNT_W-1:0] o_tile_cnt;
  logic             o_mat_done;
  logic             o_busy;

  acc_drain #(.LANES(LANES), .DATA_W(DATA_W), .ROWS(ROWS), .M(M), .N(N)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
    .i_wr_data(i_wr_data), .i_mode(i_mode), .i_relu_en(i_relu_en),
    .o_ppu_start(o_ppu_start), .o_acc_data(o_acc_data), .o_mode(o_mode),
    .o_relu_en(o_relu_en), .o_tile_cnt(o_tile_cnt), .o_mat_done(o_mat_done), .o_busy(o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Reference model: tiles filled / started / drained, plus queued expectations.
  int            n_chk = 0;
  int            n_fail = 0;
  int            filled = 0;
  int            started = 0;
  int            done = 0;
  int            rows_left = 0;
  int            rows_shown = 0;
  int            cur_tile = 0;
  logic [1:0]    cur_mode = '0;
  logic          cur_relu = 1'b0;
  bit            mat_exp = 1'b0;
  bit            mon_en = 1'b0;
  logic [RW-1:0] row_q[$];
  logic [2:0]    tag_q[$];
  int            start_q[$];

  task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fatal_timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", nm);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "timeout");
  endtask

  always @(negedge i_clk) begin
    if (mon_en) begin
      logic       exp_start;
      logic [2:0] tg;
      logic [RW-1:0] er;
      chk("wr_ready", o_wr_ready, (filled - done) < 2);
      chk("busy", o_busy, ((filled - done) > 0) || (rows_left > 0));
      chk("mat_done", o_mat_done, mat_exp);
      mat_exp = 1'b0;
      if (rows_left == 0) begin
        exp_start = filled > started;
        chk("ppu_start", o_ppu_start, exp_start);
        chk("acc_idle_zero", o_acc_data, '0);
        if (exp_start) begin
          if (tag_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL tag_queue: got empty queue, required a pending tag");
          end else begin
            tg = tag_q.pop_front();
            cur_mode = tg[1:0];
            cur_relu = tg[2];
            chk("mode_at_start", o_mode, cur_mode);
            chk("relu_at_start", o_relu_en, cur_relu);
          end
          chk("tile_cnt", o_tile_cnt, started % MAX_TILE);
          cur_tile = started % MAX_TILE;
          started++;
          rows_left = ROWS;
          rows_shown = 0;
          start_q.push_back(cyc);
        end
      end else begin
        chk("ppu_start_in_send", o_ppu_start, 1'b0);
        if (row_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL row_queue: got empty queue, required a pending row");
        end else begin
          er = row_q.pop_front();
          chk("row_data", o_acc_data, er);
        end
        chk("mode_hold", o_mode, cur_mode);
        chk("relu_hold", o_relu_en, cur_relu);
        chk("tile_cnt_hold", o_tile_cnt, cur_tile);
        rows_left--;
        rows_shown++;
        if (rows_left == 0) begin
          done++;
          if (cur_tile == MAX_TILE - 1) mat_exp = 1'b1;
        end
      end
    end
  end

  // kind 0: lane k of row r = r*16+k; kind 1: signed extremes; kind 2: random.
  task automatic send_tile(input logic [1:0] md, input logic re, input int kind, input int gap_pct);
    for (int r = 0; r < ROWS; r++) begin
      logic [RW-1:0] row_v;
      bit acc;
      int w;
      int g;
      for (int k = 0; k < LANES; k++) begin
        logic [DATA_W-1:0] lane;
        if (kind == 0)      lane = DATA_W'(r * 16 + k);
        else if (kind == 1) lane = ((k + r) % 2 == 0) ? 24'h800000 : 24'h7FFFFF;
        else                lane = DATA_W'($urandom);
        row_v[k*DATA_W +: DATA_W] = lane;
      end
      g = 0;
      while (gap_pct > 0 && g < 5 && $urandom_range(99) < gap_pct) begin
        i_wr_valid = 1'b0;
        i_wr_data  = RW'($urandom);
        g++;
        @(posedge i_clk); #1;
      end
      i_wr_valid = 1'b1;
      i_wr_data  = row_v;
      i_mode     = (r == 0) ? md : ~md;
      i_relu_en  = (r == 0) ? re : ~re;
      acc = 1'b0;
      w = 0;
      while (!acc) begin
        @(negedge i_clk);
        if (o_wr_ready) acc = 1'b1;
        else begin
          w++;
          if (w > 200) fatal_timeout("write_accept");
          @(posedge i_clk); #1;
        end
      end
      @(posedge i_clk);
      row_q.push_back(row_v);
      if (r == 0) tag_q.push_back({re, md});
      if (r == ROWS - 1) filled++;
      #1;
    end
    i_wr_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while (!(filled == done && rows_left == 0)) begin
      @(negedge i_clk); #1;
      k++;
      if (k > 3000) fatal_timeout("drain");
    end
    @(posedge i_clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ppu_start"}, o_ppu_start, 1'b0);
    chk({tag, "_acc_data"}, o_acc_data, '0);
    chk({tag, "_mode"}, o_mode, 2'd0);
    chk({tag, "_relu"}, o_relu_en, 1'b0);
    chk({tag, "_tile_cnt"}, o_tile_cnt, '0);
    chk({tag, "_mat_done"}, o_mat_done, 1'b0);
    chk({tag, "_busy"}, o_busy, 1'b0);
    chk({tag, "_wr_ready"}, o_wr_ready, 1'b1);
  endtask

  initial begin
    int c0;
    int k;
    i_rst = 1'b1;
    i_wr_valid = 1'b0;
    i_wr_data = '0;
    i_mode = '0;
    i_relu_en = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    chk_reset_outputs("reset");
    i_rst = 1'b0;
    mon_en = 1'b1;

    // Single tile from cycle 0: start must land in cycle 16.
    start_q.delete();
    c0 = cyc;
    send_tile(2'd0, 1'b0, 0, 0);
    wait_drain();
    if (start_q.size() >= 1) chk("first_start_cycle", start_q[0] - c0, 16);
    else begin n_chk++; n_fail++; $display("FAIL first_start_cycle: got no start, required cycle 16"); end

    // Three back-to-back tiles: ping-pong, backpressure, matrix wrap after tile 3.
    start_q.delete();
    send_tile(2'd0, 1'b1, 2, 0);
    send_tile(2'd1, 1'b0, 1, 0);
    send_tile(2'd2, 1'b1, 2, 0);
    wait_drain();
    if (start_q.size() == 3) begin
      chk("start_spacing_a", start_q[1] - start_q[0], 17);
      chk("start_spacing_b", start_q[2] - start_q[1], 17);
    end else begin
      n_chk++; n_fail++;
      $display("FAIL start_count: got %0d starts, required 3", start_q.size());
    end
    chk("tile_cnt_wrapped", o_tile_cnt, '0);

    // Randomized tiles with random write gaps.
    for (int t = 0; t < 6; t++)
      send_tile(2'($urandom_range(3)), 1'($urandom_range(1)), (t == 0) ? 1 : 2, 30);
    wait_drain();

    // Reset while row 7 of a transfer is presented.
    send_tile(2'd3, 1'b1, 2, 0);
    k = 0;
    while (rows_shown != 8) begin
      @(negedge i_clk); #1;
      k++;
      if (k > 200) fatal_timeout("row7_wait");
    end
    #1;
    mon_en = 1'b0;
    i_rst = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    row_q.delete();
    tag_q.delete();
    filled = 0; started = 0; done = 0; rows_left = 0; rows_shown = 0; mat_exp = 1'b0;
    @(posedge i_clk); @(posedge i_clk); #1;
    i_rst = 1'b0;
    mon_en = 1'b1;
    send_tile(2'd1, 1'b1, 2, 0);
    wait_drain();
    chk("tile_cnt_after_reset_tile", o_tile_cnt, 1);

    repeat (3) @(posedge i_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_drain.md
Name: acc_drain

Overview:
- Transmitter that feeds the post-processing unit (PPU) with accumulator tiles.
- Collects 16 rows of 16 x INT24 partial sums per tile from the systolic-array writeback into a two-bank (ping-pong) tile buffer.
- For each full bank, issues a one-cycle PPU start pulse, then streams exactly 16 rows on 16 consecutive cycles. This matches the PPU's 16-cycle row-consumption window.
- Tracks the tile count per matrix and signals matrix completion.

Parameters:
- LANES, 16, accumulator lanes per row.
- DATA_W, 24, bits per lane (signed INT24).
- ROWS, 16, rows per tile.
- M, 64, matrix rows.
- N, 64, matrix columns. Tiles per matrix MAX_TILE = (M/16)*(N/16).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_wr_valid  in  1  upstream row valid.
- o_wr_ready  out  1  current write bank not full.
- i_wr_data  in  LANES*DATA_W  one accumulator row; lane k is bits [k*DATA_W +: DATA_W].
- i_mode  in  2  mode for the tile being written; captured with row 0.
- i_relu_en  in  1  ReLU enable for the tile being written; captured with row 0.
- o_ppu_start  out  1  one-cycle start pulse to the PPU.
- o_acc_data  out  LANES*DATA_W  row currently presented to the PPU.
- o_mode  out  2  mode of the tile in flight; stable from the start pulse through row 15.
- o_relu_en  out  1  ReLU enable of the tile in flight; same stability rule as o_mode.
- o_tile_cnt  out  clog2(MAX_TILE)  index of the tile in flight.
- o_mat_done  out  1  one-cycle pulse after the last row of tile MAX_TILE-1.
- o_busy  out  1  either bank full, or a transfer in progress.

Behaviour:
- Reset values: o_ppu_start=0, o_acc_data=0, o_mode=0, o_relu_en=0, o_tile_cnt=0, o_mat_done=0, o_busy=0, o_wr_ready=1. Also: both bank-full flags 0, wr_bank=0, rd_bank=0, write row counter 0, read FSM in IDLE. Bank storage is not reset.
- Write side:
  - A row is accepted on any edge with i_wr_valid & o_wr_ready. It goes to bank wr_bank, row wr_row; wr_row then increments.
  - Row 0 acceptance also stores i_mode/i_relu_en into that bank's tag.
  - Accepting row 15: set full[wr_bank], wr_row wraps to 0, wr_bank toggles.
  - o_wr_ready = !full[wr_bank].
- Read FSM states:
  - IDLE: if full[rd_bank], then o_ppu_start=1 for this single cycle. o_mode/o_relu_en load the bank tag. Go to SEND with rd_row=0.
  - SEND: o_acc_data = bank[rd_bank][rd_row]; rd_row increments each cycle.
  - When rd_row==15: clear full[rd_bank], toggle rd_bank, and advance o_tile_cnt, wrapping MAX_TILE-1 -> 0. If that tile was MAX_TILE-1, pulse o_mat_done on the next cycle. Return to IDLE.
- Timing, with the start pulse in cycle t:
  - Rows 0..15 appear in cycles t+1..t+16.
  - o_acc_data=0 outside SEND.
  - Earliest next start is t+17, back-to-back with no idle gap.
  - The pulse spacing of ≥17 cycles is mandatory: the PPU only samples start while idle.
- Fill-to-start latency: the edge that accepts row 15 into an empty-pipeline bank sets full. o_ppu_start is high in the cycle immediately following that edge.
- The freed bank's o_wr_ready rises in cycle t+17, the cycle after row 15 is presented.
- Simultaneous fill and drain always target different banks: no conflict. A write to a full bank is impossible because ready is low.
- If both banks are full, upstream stalls (o_wr_ready=0) until the drain releases a bank.
- i_wr_valid without ready: the row is not written and counters do not move. Upstream holds its data.
- Reset mid-transfer: the FSM aborts to IDLE, all flags and counters clear, and partially written or in-flight tiles are discarded. Outputs go to their reset values asynchronously.
- Datapath: no arithmetic on data; rows pass bit-exact.

Test Plan:
- Single tile: write rows 0..15 with lane k of row r = r*16+k, back-to-back from cycle 0 (row 15 accepted at edge 15). Required: o_ppu_start high in cycle 16 only; rows 0..15 appear bit-exact in cycles 17..32; o_tile_cnt 0 -> 1 after cycle 32.
- Ping-pong: stream 3 tiles with no write gaps. Required: starts exactly 17 cycles apart; o_wr_ready drops after tile 2 fills; no row lost or duplicated; tags follow each tile (modes 0, 1, 2).
- Backpressure: hold i_wr_valid=1 with both banks full. Required: o_wr_ready=0 until cycle t+17 of the first transfer; the stalled row is accepted exactly once.
- Matrix wrap with M=N=32 (4 tiles): send 4 tiles. Required: o_mat_done pulses once, one cycle after the last row of tile 3; o_tile_cnt returns to 0.
- Signed data: lanes = 24'h800000 and 24'h7FFFFF. Required: values appear unchanged on o_acc_data.
- Reset at row 7 of SEND: assert i_rst. Required: all outputs immediately at reset values, o_wr_ready=1; a new tile afterward drains normally with o_tile_cnt=0.
